dsp_mac_sequencer: RTL and testbench

Control-side companion to the DSP48A1 slice: accepts a stream of (A, B) operand pairs grouped into vectors, drives the slice's operand, OPMODE and clock-enable inputs so that it accumulates a dot product, then reads P back and queues one 48-bit result per vector. It sits between a valid/ready operand source and one slice, and is the only agent driving that slice's control ports.

---
 rtl/dsp_mac_sequencer.sv | 131 +++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as a dot-product engine: operand pairs in,
// one 48-bit accumulated result plus element count out per vector.
module dsp_mac_sequencer #(
    parameter int RES_DEPTH = 4,
    parameter int LEN_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [17:0]      S_A,
    input  logic [17:0]      S_B,
    input  logic             S_SUB,
    input  logic             S_LAST,
    output logic             R_VALID,
    input  logic             R_READY,
    output logic [47:0]      R_DATA,
    output logic [LEN_W-1:0] R_LEN,
    output logic [17:0]      DSP_A,
    output logic [17:0]      DSP_B,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CEA,
    output logic             DSP_CEB,
    output logic             DSP_CEM,
    output logic             DSP_CEOPMODE,
    output logic             DSP_CEP,
    output logic             DSP_RST,
    input  logic [47:0]      DSP_P
);

    localparam int AW = $clog2(RES_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic             in_vector;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_new;

    logic             v1, first1, sub1, last1;
    logic [LEN_W-1:0] len1;
    logic             v2, last2;
    logic [LEN_W-1:0] len2;
    logic             v3;
    logic [LEN_W-1:0] len3;

    logic [47:0]      mem_d [RES_DEPTH];
    logic [LEN_W-1:0] mem_l [RES_DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic [CW:0]      used;

    logic take, push, pop;

    // Credit covers results already queued plus vectors whose LAST is still
    // travelling through the slice, so a push always finds a free entry.
    assign used = {1'b0, count}
                + (CW+1)'(v1 & last1)
                + (CW+1)'(v2 & last2)
                + (CW+1)'(v3);

    assign S_READY = !RST && (used < (CW+1)'(RES_DEPTH));
    assign take    = S_VALID & S_READY;
    assign push    = v3;
    assign pop     = R_VALID & R_READY;

    assign len_new = !in_vector      ? LEN_W'(1) :
                     (cnt == LEN_MAX) ? cnt       : cnt + LEN_W'(1);

    assign DSP_RST      = RST;
    assign DSP_A        = take ? S_A : '0;
    assign DSP_B        = take ? S_B : '0;
    assign DSP_CEA      = take;
    assign DSP_CEB      = take;
    assign DSP_CEM      = v1 & !RST;
    assign DSP_CEOPMODE = v1 & !RST;
    assign DSP_CEP      = v2 & !RST;

    // X=M always; Z=P except on the first element, where Z=0 drops old P.
    assign DSP_OPMODE = (v1 && !RST) ?
        {sub1, 3'b000, !first1, 2'b00, 1'b1} : 8'h00;

    assign R_VALID = (count != '0);
    assign R_DATA  = R_VALID ? mem_d[rptr] : '0;
    assign R_LEN   = R_VALID ? mem_l[rptr] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_vector <= 1'b0;
            cnt       <= '0;
            v1        <= 1'b0;
            first1    <= 1'b0;
            sub1      <= 1'b0;
            last1     <= 1'b0;
            len1      <= '0;
            v2        <= 1'b0;
            last2     <= 1'b0;
            len2      <= '0;
            v3        <= 1'b0;
            len3      <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
        end else begin
            v1     <= take;
            first1 <= !in_vector;
            sub1   <= S_SUB;
            last1  <= S_LAST;
            len1   <= len_new;
            if (take) begin
                in_vector <= !S_LAST;
                cnt       <= len_new;
            end
            v2    <= v1;
            last2 <= last1;
            len2  <= len1;
            v3    <= v2 & last2;
            len3  <= len2;
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem_d[wptr] <= DSP_P;
            mem_l[wptr] <= len3;
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice plus a
// vector-level dot-product model; directed and random vectors.
module tb_dsp_mac_sequencer;

    localparam int LEN_W = 8;
    localparam int LMAX  = (1 << LEN_W) - 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             S_VALID, S_READY;
    logic [17:0]      S_A, S_B;
    logic             S_SUB, S_LAST;
    logic             R_VALID, R_READY;
    logic [47:0]      R_DATA;
    logic [LEN_W-1:0] R_LEN;
    logic [17:0]      DSP_A, DSP_B;
    logic [7:0]       DSP_OPMODE;
    logic             DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP;
    logic             DSP_RST;
    logic [47:0]      DSP_P;

    dsp_mac_sequencer #(.RES_DEPTH(4), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST),
        .S_VALID(S_VALID), .S_READY(S_READY),
        .S_A(S_A), .S_B(S_B), .S_SUB(S_SUB), .S_LAST(S_LAST),
        .R_VALID(R_VALID), .R_READY(R_READY),
        .R_DATA(R_DATA), .R_LEN(R_LEN),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE),
        .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB), .DSP_CEM(DSP_CEM),
        .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_CEP(DSP_CEP),
        .DSP_RST(DSP_RST), .DSP_P(DSP_P)
    );

    always #5 CLK = ~CLK;

    // Slice model: A1/B1 -> M -> P with OPMODE register, sync reset.
    logic signed [17:0] a1, b1;
    logic signed [35:0] m;
    logic [7:0]         opr;
    logic [47:0]        p, xm, zp;
    assign xm = (opr[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'h0;
    assign zp = (opr[3:2] == 2'b10) ? p : 48'h0;
    assign DSP_P = p;
    always @(posedge CLK) begin
        if (DSP_RST) begin
            a1 <= '0; b1 <= '0; m <= '0; opr <= '0; p <= '0;
        end else begin
            if (DSP_CEA) a1 <= DSP_A;
            if (DSP_CEB) b1 <= DSP_B;
            if (DSP_CEM) m <= a1 * b1;
            if (DSP_CEOPMODE) opr <= DSP_OPMODE;
            if (DSP_CEP) p <= opr[7] ? zp - xm : zp + xm;
        end
    end

    typedef struct {
        logic [47:0] d;
        int          l;
        int          c;
    } res_t;

    res_t   got[$];
    res_t   exp[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     rv_cnt = 0;
    int     cep_cnt = 0;
    logic   hold_v = 1'b0;
    logic [47:0] hold_d;
    longint macc = 0;
    int     mlen = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, want);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (R_VALID && R_READY && !RST)
            got.push_back('{R_DATA, int'(R_LEN), cyc});
        if (R_VALID) rv_cnt++;
        if (DSP_CEP) cep_cnt++;
        if (hold_v && R_VALID && !RST)
            check("hold_data", {16'h0, R_DATA}, {16'h0, hold_d});
        hold_v = R_VALID && !R_READY && !RST;
        hold_d = R_DATA;
    end

    task automatic m_elem(input logic [17:0] a, input logic [17:0] b,
                          input logic sub, input logic last);
        longint pr;
        pr = longint'($signed(a)) * longint'($signed(b));
        macc = sub ? macc - pr : macc + pr;
        mlen++;
        if (last) begin
            exp.push_back('{macc[47:0], (mlen > LMAX) ? LMAX : mlen, 0});
            macc = 0;
            mlen = 0;
        end
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b,
                        input logic sub, input logic last,
                        output int acc);
        int k;
        S_A = a; S_B = b; S_SUB = sub; S_LAST = last; S_VALID = 1'b1;
        k = 0;
        forever begin
            @(negedge CLK);
            if (S_READY || k > 400) break;
            k++;
            @(posedge CLK); #1;
            R_READY = 1'b1;
        end
        check("send_ready", 64'(S_READY), 64'd1);
        acc = cyc;
        @(posedge CLK); #1;
        S_VALID = 1'b0;
        m_elem(a, b, sub, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic wait_results(input string tag);
        int k;
        R_READY = 1'b1;
        k = 0;
        while (got.size() < exp.size() && k < 3000) begin
            @(posedge CLK); #1; k++;
        end
        idle(3);
        check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check({tag, "_data"}, {16'h0, got[i].d}, {16'h0, exp[i].d});
            check({tag, "_len"}, 64'(got[i].l), 64'(exp[i].l));
        end
    endtask

    initial begin
        int n, t, hits, nv, gap;
        logic [17:0] ra, rb;
        RST = 1'b1; S_VALID = 1'b0; S_A = '0; S_B = '0;
        S_SUB = 1'b0; S_LAST = 1'b0; R_READY = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_s_ready", 64'(S_READY), 64'd0);
        check("rst_r_valid", 64'(R_VALID), 64'd0);
        check("rst_r_data", {16'h0, R_DATA}, 64'd0);
        check("rst_r_len", 64'(R_LEN), 64'd0);
        check("rst_dsp_rst", 64'(DSP_RST), 64'd1);
        check("rst_opmode", 64'(DSP_OPMODE), 64'd0);
        check("rst_ces", 64'({DSP_CEA, DSP_CEB, DSP_CEM,
                              DSP_CEOPMODE, DSP_CEP}), 64'd0);
        check("rst_dsp_ab", 64'({DSP_A, DSP_B}), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("run_dsp_rst", 64'(DSP_RST), 64'd0);
        check("run_s_ready", 64'(S_READY), 64'd1);
        @(posedge CLK); #1;

        // back-to-back pair, latency and single-cycle R_VALID
        got.delete(); exp.delete(); rv_cnt = 0;
        send(18'd2, 18'd3, 1'b0, 1'b0, n);
        send(18'd4, 18'd5, 1'b0, 1'b1, n);
        wait_results("t1");
        if (got.size() > 0) begin
            check("t1_value", {16'h0, got[0].d}, 64'd26);
            check("t1_rlen", 64'(got[0].l), 64'd2);
            check("t1_latency", 64'(got[0].c), 64'(n + 4));
        end
        check("t1_rv_cycles", 64'(rv_cnt), 64'd1);

        // same vector with bubbles between elements
        got.delete(); exp.delete(); cep_cnt = 0;
        send(18'd2, 18'd3, 1'b0, 1'b0, n);
        idle(3);
        send(18'd4, 18'd5, 1'b0, 1'b1, n);
        wait_results("t2");
        if (got.size() > 0)
            check("t2_value", {16'h0, got[0].d}, 64'd26);
        check("t2_cep_pulses", 64'(cep_cnt), 64'd2);

        // subtraction, including a negative single-element result
        got.delete(); exp.delete();
        send(18'd10, 18'd10, 1'b0, 1'b0, n);
        send(18'd3, 18'd4, 1'b1, 1'b1, n);
        send(18'd7, 18'd1, 1'b1, 1'b1, n);
        wait_results("t3");
        if (got.size() > 1) begin
            check("t3_value_a", {16'h0, got[0].d}, 64'd88);
            check("t3_value_b", {16'h0, got[1].d}, 64'h0000_FFFF_FFFF_FFF9);
        end

        // result FIFO full: credit must stall the fifth vector
        got.delete(); exp.delete();
        R_READY = 1'b0;
        for (int k = 1; k <= 4; k++)
            send(18'(k), 18'd1, 1'b0, 1'b1, n);
        S_A = 18'd5; S_B = 18'd1; S_SUB = 1'b0; S_LAST = 1'b1;
        S_VALID = 1'b1;
        hits = 0;
        repeat (8) begin
            @(negedge CLK);
            if (S_READY) hits++;
        end
        check("full_stall", 64'(hits), 64'd0);
        check("full_r_valid", 64'(R_VALID), 64'd1);
        check("full_head", {16'h0, R_DATA}, 64'd1);
        @(posedge CLK); #1;
        R_READY = 1'b1;
        send(18'd5, 18'd1, 1'b0, 1'b1, n);
        wait_results("t4");

        // reset in the middle of a vector discards it
        got.delete(); exp.delete();
        send(18'd9, 18'd9, 1'b0, 1'b0, n);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_dsp_rst", 64'(DSP_RST), 64'd1);
        check("mid_cem", 64'(DSP_CEM), 64'd0);
        check("mid_s_ready", 64'(S_READY), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        macc = 0; mlen = 0;
        idle(6);
        check("mid_no_result", 64'(got.size()), 64'd0);
        send(18'd1, 18'd1, 1'b0, 1'b1, n);
        wait_results("t5");
        if (got.size() > 0) begin
            check("t5_value", {16'h0, got[0].d}, 64'd1);
            check("t5_rlen", 64'(got[0].l), 64'd1);
        end

        // long vector: length saturates, sum does not
        got.delete(); exp.delete();
        for (int k = 0; k < 300; k++)
            send(18'd1, 18'd1, 1'b0, (k == 299), n);
        wait_results("t6");
        if (got.size() > 0) begin
            check("t6_value", {16'h0, got[0].d}, 64'd300);
            check("t6_rlen", 64'(got[0].l), 64'd255);
        end

        // random vectors, gaps and consumer back-pressure
        got.delete(); exp.delete();
        for (int v = 0; v < 40; v++) begin
            nv = $urandom_range(1, 6);
            for (int e = 0; e < nv; e++) begin
                R_READY = ($urandom_range(0, 3) != 0);
                ra = 18'($urandom);
                rb = 18'($urandom);
                send(ra, rb, 1'($urandom), (e == nv - 1), t);
                gap = $urandom_range(0, 2);
                idle(gap);
            end
        end
        wait_results("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
